// File: rtl/dlsc_pcie_s6_inbound_trans_arb.sv
// dlsc_pcie_s6_inbound_trans_arb: round-robin share of one inbound address translator among PORTS requesters
module dlsc_pcie_s6_inbound_trans_arb #(
  parameter int PORTS = 2,
  parameter int ADDR  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORTS-1:0]    in_req,
  input  logic [3*PORTS-1:0]  in_bar,
  input  logic [62*PORTS-1:0] in_addr,
  input  logic [PORTS-1:0]    in_64,
  output logic [PORTS-1:0]    in_ack,
  output logic [ADDR-3:0]     in_ack_addr,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                trans_req,
  output logic [2:0]          trans_req_bar,
  output logic [61:0]         trans_req_addr,
  output logic                trans_req_64,
  input  logic                trans_ack,
  input  logic [ADDR-3:0]     trans_ack_addr
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d, grant_q, grant_d, bar_q, bar_d, win;
  logic [61:0] addr_q, addr_d;
  logic        w64_q, w64_d, req_q, req_d, req_g;
  assign grant_id       = grant_q;
  assign busy           = state_q != IDLE;
  assign trans_req      = req_q;
  assign trans_req_bar  = bar_q;
  assign trans_req_addr = addr_q;
  assign trans_req_64   = w64_q;
  assign in_ack_addr    = trans_ack_addr;
  assign req_g          = |(in_req & (PORTS'(1) << grant_q));
  assign in_ack         = (state_q == GRANT && trans_ack) ? PORTS'(1) << grant_q : '0;
  // pick the first requester above the pointer (downward scan keeps the nearest), then step the FSM
  always_comb begin
    win = '0;
    for (int i = PORTS; i >= 1; i--)
      if (|(in_req & (PORTS'(1) << ((int'(ptr_q) + i) % PORTS)))) win = 3'((int'(ptr_q) + i) % PORTS);
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    bar_d   = bar_q;
    addr_d  = addr_q;
    w64_d   = w64_q;
    req_d   = req_q;
    if (state_q == IDLE && |in_req) begin
      state_d = GRANT;
      ptr_d   = win;
      grant_d = win;
      bar_d   = in_bar[3*int'(win) +: 3];
      addr_d  = in_addr[62*int'(win) +: 62];
      w64_d   = in_64[win];
      req_d   = 1'b1;
    end
    if (state_q == GRANT && !req_g) begin
      state_d = GAP;
      req_d   = 1'b0;
    end
    if (state_q == GAP) state_d = IDLE;
  end
  // state and captured request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'(PORTS-1);
      grant_q <= '0;
      bar_q   <= '0;
      addr_q  <= '0;
      w64_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      bar_q   <= bar_d;
      addr_q  <= addr_d;
      w64_q   <= w64_d;
      req_q   <= req_d;
    end
  end
endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_trans_arb.sv
// tb_dlsc_pcie_s6_inbound_trans_arb: directed checks of the translator arbiter (2-port and 4-port instances)
module tb_dlsc_pcie_s6_inbound_trans_arb;
  logic         clk = 0, rst_n = 0;
  logic [1:0]   in_req = 0, in_64 = 0, in_ack;
  logic [5:0]   in_bar = 0;
  logic [123:0] in_addr = 0;
  logic [29:0]  in_ack_addr, trans_ack_addr = 0;
  logic [2:0]   grant_id, trans_req_bar;
  logic [61:0]  trans_req_addr;
  logic         busy, trans_req, trans_req_64, trans_ack = 0;
  logic [3:0]   r4 = 0, ack4;
  logic [11:0]  bar4 = 0;
  logic [247:0] addr4 = 0;
  logic [29:0]  aa4;
  logic [2:0]   gid4, tb4;
  logic [61:0]  ta4;
  logic         busy4, treq4, t644, tack4 = 0;
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  dlsc_pcie_s6_inbound_trans_arb #(.PORTS(2), .ADDR(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_bar(in_bar), .in_addr(in_addr), .in_64(in_64),
    .in_ack(in_ack), .in_ack_addr(in_ack_addr), .grant_id(grant_id), .busy(busy), .trans_req(trans_req),
    .trans_req_bar(trans_req_bar), .trans_req_addr(trans_req_addr), .trans_req_64(trans_req_64),
    .trans_ack(trans_ack), .trans_ack_addr(trans_ack_addr));
  dlsc_pcie_s6_inbound_trans_arb #(.PORTS(4), .ADDR(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_req(r4), .in_bar(bar4), .in_addr(addr4), .in_64(4'b0),
    .in_ack(ack4), .in_ack_addr(aa4), .grant_id(gid4), .busy(busy4), .trans_req(treq4),
    .trans_req_bar(tb4), .trans_req_addr(ta4), .trans_req_64(t644),
    .trans_ack(tack4), .trans_ack_addr(30'h0));
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    total_cnt++; if (trans_req !== 1'b0) $display("FAIL rst_trans_req got %b want 0", trans_req); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (grant_id !== 3'd0) $display("FAIL rst_grant_id got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (in_ack !== 2'b00) $display("FAIL rst_in_ack got %b want 00", in_ack); else pass_cnt++;
    total_cnt++; if (trans_req_addr !== 62'h0 || trans_req_bar !== 3'd0) $display("FAIL rst_fields got %h/%0d want 0/0", trans_req_addr, trans_req_bar); else pass_cnt++;
    rst_n = 1;
  endtask
  task automatic test_single();
    in_req = 2'b01; in_bar = 6'o02; in_addr = {62'h0, 62'h1234};
    tick();
    total_cnt++; if (trans_req !== 1'b1) $display("FAIL single_req got %b want 1", trans_req); else pass_cnt++;
    total_cnt++; if (trans_req_bar !== 3'd2 || trans_req_addr !== 62'h1234 || trans_req_64 !== 1'b0)
      $display("FAIL single_fields got %0d/%h/%b want 2/1234/0", trans_req_bar, trans_req_addr, trans_req_64); else pass_cnt++;
    total_cnt++; if (in_ack !== 2'b00 || busy !== 1'b1) $display("FAIL single_preack got %b/%b want 00/1", in_ack, busy); else pass_cnt++;
    tick();
    tick();
    trans_ack = 1; trans_ack_addr = 30'h0ABC;
    #1;
    total_cnt++; if (in_ack !== 2'b01) $display("FAIL single_ack got %b want 01", in_ack); else pass_cnt++;
    total_cnt++; if (in_ack_addr !== 30'h0ABC) $display("FAIL single_ack_addr got %h want 0abc", in_ack_addr); else pass_cnt++;
    tick();
    in_req = 0; trans_ack = 0;
    tick();
    total_cnt++; if (trans_req !== 1'b0 || busy !== 1'b1) $display("FAIL single_gap got %b/%b want 0/1", trans_req, busy); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle got %b want 0", busy); else pass_cnt++;
  endtask
  task automatic test_two();
    test_reset();
    in_req = 2'b11; in_addr = {62'h2_BBBB, 62'h1_AAAA}; in_bar = 6'o53; in_64 = 2'b10;
    tick();
    total_cnt++; if (grant_id !== 3'd0 || trans_req_addr !== 62'h1_AAAA) $display("FAIL two_first got %0d/%h want 0/1aaaa", grant_id, trans_req_addr); else pass_cnt++;
    in_req = 2'b10;
    tick();
    total_cnt++; if (trans_req !== 1'b0 || grant_id !== 3'd0) $display("FAIL two_gap got %b/%0d want 0/0", trans_req, grant_id); else pass_cnt++;
    tick();
    total_cnt++; if (trans_req !== 1'b0 || busy !== 1'b0) $display("FAIL two_idle got %b/%b want 0/0", trans_req, busy); else pass_cnt++;
    tick();
    total_cnt++; if (trans_req !== 1'b1 || grant_id !== 3'd1 || trans_req_addr !== 62'h2_BBBB || trans_req_bar !== 3'd5 || trans_req_64 !== 1'b1)
      $display("FAIL two_second got %b/%0d/%h/%0d/%b want 1/1/2bbbb/5/1", trans_req, grant_id, trans_req_addr, trans_req_bar, trans_req_64); else pass_cnt++;
    in_req = 0;
    tick();
    tick();
  endtask
  task automatic test_abort();
    in_req = 2'b10;
    tick();
    total_cnt++; if (grant_id !== 3'd1 || trans_req !== 1'b1) $display("FAIL abort_grant got %0d/%b want 1/1", grant_id, trans_req); else pass_cnt++;
    in_req = 0;
    tick();
    total_cnt++; if (in_ack !== 2'b00 || trans_req !== 1'b0 || busy !== 1'b1) $display("FAIL abort_gap got %b/%b/%b want 00/0/1", in_ack, trans_req, busy); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_idle got %b want 0", busy); else pass_cnt++;
  endtask
  task automatic test_stale_ack();
    in_req = 2'b11;
    tick();
    trans_ack = 1;
    #1;
    total_cnt++; if (grant_id !== 3'd0 || in_ack !== 2'b01) $display("FAIL stale_grant0 got %0d/%b want 0/01", grant_id, in_ack); else pass_cnt++;
    in_req = 2'b10;
    #1;
    total_cnt++; if (in_ack !== 2'b01) $display("FAIL stale_same_cycle got %b want 01", in_ack); else pass_cnt++;
    tick();
    total_cnt++; if (in_ack !== 2'b00 || trans_req !== 1'b0) $display("FAIL stale_gap got %b/%b want 00/0", in_ack, trans_req); else pass_cnt++;
    tick();
    total_cnt++; if (in_ack !== 2'b00 || busy !== 1'b0) $display("FAIL stale_idle got %b/%b want 00/0", in_ack, busy); else pass_cnt++;
    tick();
    total_cnt++; if (grant_id !== 3'd1 || trans_req !== 1'b1 || in_ack !== 2'b10) $display("FAIL stale_grant1 got %0d/%b/%b want 1/1/10", grant_id, trans_req, in_ack); else pass_cnt++;
    in_req = 0; trans_ack = 0;
    tick();
    tick();
  endtask
  task automatic test_reset_mid();
    in_req = 2'b10;
    tick();
    trans_ack = 1;
    total_cnt++; if (grant_id !== 3'd1 || trans_req !== 1'b1) $display("FAIL rmid_grant got %0d/%b want 1/1", grant_id, trans_req); else pass_cnt++;
    rst_n = 0;
    tick();
    total_cnt++; if (trans_req !== 1'b0 || in_ack !== 2'b00 || busy !== 1'b0) $display("FAIL rmid_reset got %b/%b/%b want 0/00/0", trans_req, in_ack, busy); else pass_cnt++;
    rst_n = 1; trans_ack = 0; in_req = 2'b11;
    tick();
    total_cnt++; if (grant_id !== 3'd0 || trans_req !== 1'b1) $display("FAIL rmid_regrant got %0d/%b want 0/1", grant_id, trans_req); else pass_cnt++;
    in_req = 0;
    tick();
    tick();
  endtask
  task automatic test_round_robin4();
    logic [2:0] exp_g [5];
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    addr4 = {62'h33, 62'h22, 62'h11, 62'h00};
    r4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      total_cnt++; if (gid4 !== exp_g[k] || treq4 !== 1'b1) $display("FAIL rr4_grant%0d got %0d/%b want %0d/1", k, gid4, treq4, exp_g[k]); else pass_cnt++;
      tack4 = 1;
      #1;
      total_cnt++; if (ack4 !== (4'b1 << exp_g[k])) $display("FAIL rr4_ack%0d got %b want %b", k, ack4, 4'b1 << exp_g[k]); else pass_cnt++;
      tick();
      r4[exp_g[k]] = 1'b0; tack4 = 0;
      tick();
      r4 = 4'hF;
      tick();
    end
    r4 = 0;
  endtask
  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_two();
        test_abort();
        test_stale_ack();
        test_reset_mid();
        test_round_robin4();
      end
      begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
      end
    join_any
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
